// File: rtl/step_motor_ctl.sv
// step_motor_ctl: per-axis STEP/DIR pulse generator with position/remain tracking
// and 2-flop synchronizers for the zero-point and terminal-point limit sensors.
// Build option: define STEP_MOTOR_LIMIT_STOP_EN to refuse pulses that would drive
// the axis further into an active limit sensor.
module step_motor_ctl #(
  parameter int C_SPEED_DATA_WIDTH  = 32,
  parameter int C_STEP_NUMBER_WIDTH = 16,
  parameter int C_DIR_SETUP         = 4
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           start,
  input  logic                           stop,
  input  logic [C_SPEED_DATA_WIDTH-1:0]  speed,
  input  logic [C_STEP_NUMBER_WIDTH-1:0] step,
  input  logic                           dir,
  input  logic                           mod_remain,
  input  logic [C_STEP_NUMBER_WIDTH-1:0] new_remain,
  input  logic                           zpsign_raw,
  input  logic                           tpsign_raw,
  output logic                           zpsign,
  output logic                           tpsign,
  output logic                           state,
  output logic [C_STEP_NUMBER_WIDTH-1:0] position,
  output logic [C_STEP_NUMBER_WIDTH-1:0] remain,
  output logic                           motor_step,
  output logic                           motor_dir
);

  localparam int SW = C_SPEED_DATA_WIDTH;
  localparam int NW = C_STEP_NUMBER_WIDTH;
  localparam int CW = (C_DIR_SETUP > 1) ? $clog2(C_DIR_SETUP) : 1;
  localparam logic [CW-1:0] SETUP_LOAD = CW'(C_DIR_SETUP - 1);
  localparam logic [SW-1:0] MIN_PERIOD = SW'(2);

  // state | meaning
  // IDLE  | no move; motor_step low
  // SETUP | DIR settling, setup_cnt counts down to the first pulse
  // RUN   | issuing pulses, cnt walks 0..P-1 within each step period
  typedef enum logic [1:0] {IDLE, SETUP, RUN} state_t;

  state_t          st_q, st_d;
  logic [SW-1:0]   period_q, period_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   setup_cnt_q, setup_cnt_d;
  logic [NW-1:0]   position_q, position_d;
  logic [NW-1:0]   remain_q, remain_d;
  logic            dir_q, dir_d;
  logic            motor_step_q, motor_step_d;
  logic [1:0]      zp_sync_q, zp_sync_d;
  logic [1:0]      tp_sync_q, tp_sync_d;

  logic [NW-1:0]   rem_eff;
  logic [SW-1:0]   cnt_nxt;
  logic            blocked;
  logic            issue;

  // Next-state, counters and pulse generation.
  always_comb begin
    st_d          = st_q;
    period_d      = period_q;
    cnt_d         = cnt_q;
    setup_cnt_d   = setup_cnt_q;
    position_d    = position_q;
    remain_d      = remain_q;
    dir_d         = dir_q;
    motor_step_d  = 1'b0;
    zp_sync_d     = {zp_sync_q[0], zpsign_raw};
    tp_sync_d     = {tp_sync_q[0], tpsign_raw};
    issue         = 1'b0;
    cnt_nxt       = cnt_q + SW'(1);
    // An overwrite in this cycle already governs this cycle's issue decision.
    rem_eff       = mod_remain ? new_remain : remain_q;
`ifdef STEP_MOTOR_LIMIT_STOP_EN
    blocked       = dir_q ? tp_sync_q[1] : zp_sync_q[1];
`else
    blocked       = 1'b0;
`endif

    case (st_q)
      IDLE: begin
        if (start && !stop && (step != '0)) begin
          st_d        = SETUP;
          period_d    = (speed < MIN_PERIOD) ? MIN_PERIOD : speed;
          remain_d    = step;
          dir_d       = dir;
          setup_cnt_d = SETUP_LOAD;
        end
      end
      SETUP: begin
        if (stop) begin
          st_d = IDLE;
        end else begin
          remain_d = rem_eff;
          if (rem_eff == '0) begin
            st_d = IDLE;
          end else if (setup_cnt_q == '0) begin
            if (blocked) st_d = IDLE;
            else         issue = 1'b1;
          end else begin
            setup_cnt_d = setup_cnt_q - CW'(1);
          end
        end
      end
      RUN: begin
        if (stop) begin
          st_d = IDLE;
        end else begin
          remain_d = rem_eff;
          if (cnt_q == period_q - SW'(1)) begin
            if ((rem_eff == '0) || blocked) st_d = IDLE;
            else                            issue = 1'b1;
          end else begin
            cnt_d        = cnt_nxt;
            motor_step_d = (cnt_nxt < (period_q >> 1));
          end
        end
      end
      default: st_d = IDLE;
    endcase

    if (issue) begin
      st_d         = RUN;
      cnt_d        = '0;
      motor_step_d = 1'b1;
      position_d   = dir_q ? position_q + NW'(1) : position_q - NW'(1);
      remain_d     = rem_eff - NW'(1);
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      st_q         <= IDLE;
      period_q     <= MIN_PERIOD;
      cnt_q        <= '0;
      setup_cnt_q  <= '0;
      position_q   <= '0;
      remain_q     <= '0;
      dir_q        <= 1'b0;
      motor_step_q <= 1'b0;
      zp_sync_q    <= '0;
      tp_sync_q    <= '0;
    end else begin
      st_q         <= st_d;
      period_q     <= period_d;
      cnt_q        <= cnt_d;
      setup_cnt_q  <= setup_cnt_d;
      position_q   <= position_d;
      remain_q     <= remain_d;
      dir_q        <= dir_d;
      motor_step_q <= motor_step_d;
      zp_sync_q    <= zp_sync_d;
      tp_sync_q    <= tp_sync_d;
    end
  end

  assign state      = (st_q != IDLE);
  assign position   = position_q;
  assign remain     = remain_q;
  assign motor_step = motor_step_q;
  assign motor_dir  = dir_q;
  assign zpsign     = zp_sync_q[1];
  assign tpsign     = tp_sync_q[1];

endmodule
